// File: rtl/core_pkg.sv
// Shared types and constants for the 5-stage core hazard logic.
package core_pkg;

  localparam int unsigned REG_AW = 4;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    BR_SHADOW
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/fwd_unit.sv
// E-stage operand forwarding select for one source operand (purely combinational).
module fwd_unit
  import core_pkg::*;
#(
  parameter int unsigned REG_AW = core_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] ra_e_i,
  input  logic [REG_AW-1:0] wa3_m_i,
  input  logic [REG_AW-1:0] wa3_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        fwd_o
);

  // M beats W (younger result); the PC register always comes from the register file.
  always_comb begin
    fwd_o = FWD_RF;
    if (ra_e_i != REG_AW'(PC_REG)) begin
      if (reg_write_m_i && (wa3_m_i == ra_e_i)) begin
        fwd_o = FWD_M;
      end else if (reg_write_w_i && (wa3_w_i == ra_e_i)) begin
        fwd_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stall, branch flush with a
// one-cycle redirect shadow, and data-memory wait with timeout.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_AW      = core_pkg::REG_AW,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  input  logic              use1D,
  input  logic              use2D,
  input  logic [REG_AW-1:0] ra1E,
  input  logic [REG_AW-1:0] ra2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              regWriteE,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic              memToRegE,
  input  logic              PCSrcE,
  input  logic              memReqM,
  input  logic              memReadyM,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  hz_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       ld_haz;
  logic       mem_stall;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ra_e_i        (ra1E),
    .wa3_m_i       (WA3M),
    .wa3_w_i       (WA3W),
    .reg_write_m_i (regWriteM),
    .reg_write_w_i (regWriteW),
    .fwd_o         (forwardAE)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ra_e_i        (ra2E),
    .wa3_m_i       (WA3M),
    .wa3_w_i       (WA3W),
    .reg_write_m_i (regWriteM),
    .reg_write_w_i (regWriteW),
    .fwd_o         (forwardBE)
  );

  assign ld_haz = memToRegE && regWriteE &&
                  ((use1D && (ra1D == WA3E)) || (use2D && (ra2D == WA3E)));
  assign mem_stall = memReqM && !memReadyM;
  assign mem_err   = err_q;

  // Next-state and pipeline control; priority is memory wait > branch > load-use.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          {stallF, stallD, stallE, stallM} = 4'b1111;
          state_d = MEM_WAIT;
          cnt_d   = 8'd0;
        end else if (PCSrcE) begin
          flushD  = 1'b1;
          flushE  = 1'b1;
          state_d = BR_SHADOW;
        end else if (ld_haz) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        {stallF, stallD, stallE, stallM} = 4'b1111;
        if (memReadyM) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
          // Give up on the access; pipeline resumes and the error stays sticky.
          err_d   = 1'b1;
          state_d = RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BR_SHADOW: begin
        if (mem_stall) begin
          {stallF, stallD, stallE, stallM} = 4'b1111;
          state_d = MEM_WAIT;
          cnt_d   = 8'd0;
        end else begin
          flushD  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, timeout counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Saturating counts of stallD and flushE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stallD && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flushE && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W;
  logic       use1D, use2D, regWriteE, regWriteM, regWriteW;
  logic       memToRegE, PCSrcE, memReqM, memReadyM;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, mem_err;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  int unsigned m_stall_cnt = 0;
  int unsigned m_flush_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(4), .MEM_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ra1D      (ra1D),
    .ra2D      (ra2D),
    .use1D     (use1D),
    .use2D     (use2D),
    .ra1E      (ra1E),
    .ra2E      (ra2E),
    .WA3E      (WA3E),
    .WA3M      (WA3M),
    .WA3W      (WA3W),
    .regWriteE (regWriteE),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .memToRegE (memToRegE),
    .PCSrcE    (PCSrcE),
    .memReqM   (memReqM),
    .memReadyM (memReadyM),
    .stallF    (stallF),
    .stallD    (stallD),
    .stallE    (stallE),
    .stallM    (stallM),
    .flushD    (flushD),
    .flushE    (flushE),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE),
    .mem_err   (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Packs {stallF,stallD,stallE,stallM,flushD,flushE,forwardAE,forwardBE,mem_err}.
  function automatic logic [10:0] mk(input logic [3:0] st, input logic fd, input logic fe,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic err);
    return {st, fd, fe, fa, fb, err};
  endfunction

  task automatic clear_inputs();
    ra1D = 0; ra2D = 0; ra1E = 0; ra2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    use1D = 0; use2D = 0; regWriteE = 0; regWriteM = 0; regWriteW = 0;
    memToRegE = 0; PCSrcE = 0; memReqM = 0; memReadyM = 0;
  endtask

  // Queue the expectation for the current cycle, compare at negedge, move to next cycle.
  task automatic cyc(input string tag, input logic [10:0] exp);
    sb_item_t it;
    logic [10:0] got;
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    it  = sb_q.pop_front();
    got = {stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE, mem_err};
    checks++;
    assert (got === it.exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", it.tag, got, it.exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert (stall_cnt === 16'(m_stall_cnt) && flush_cnt === 16'(m_flush_cnt)) else begin
      errors++;
      $error("FAIL %s_perf: observed %0d/%0d expected %0d/%0d", it.tag, stall_cnt, flush_cnt,
             m_stall_cnt, m_flush_cnt);
    end
    if (rst) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (it.exp[9] && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
      if (it.exp[5] && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    rst = 1'b0;

    // Forwarding
    ra1E = 3; ra2E = 3; regWriteM = 1; WA3M = 3; regWriteW = 1; WA3W = 3;
    cyc("fwd_m_prio", mk(4'b0000, 0, 0, 2'b10, 2'b10, 0));
    regWriteM = 0;
    cyc("fwd_w", mk(4'b0000, 0, 0, 2'b01, 2'b01, 0));
    regWriteM = 1; ra1E = 15; WA3M = 15; WA3W = 15; ra2E = 7;
    cyc("fwd_pc", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    WA3M = 2; ra2E = 2;
    cyc("fwd_b_only", mk(4'b0000, 0, 0, 2'b00, 2'b10, 0));
    clear_inputs();

    // Load-use
    memToRegE = 1; regWriteE = 1; WA3E = 5; ra2D = 5; use2D = 1;
    cyc("lduse", mk(4'b1100, 0, 1, 2'b00, 2'b00, 0));
    memToRegE = 0;
    cyc("lduse_done", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    memToRegE = 1; use2D = 0;
    cyc("lduse_nouse", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    clear_inputs();

    // Branch flush and shadow
    PCSrcE = 1;
    cyc("br_n", mk(4'b0000, 1, 1, 2'b00, 2'b00, 0));
    PCSrcE = 0;
    cyc("br_n1", mk(4'b0000, 1, 0, 2'b00, 2'b00, 0));
    cyc("br_n2", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

    // Memory wait, ready after 3 low cycles
    memReqM = 1;
    for (int i = 0; i < 3; i++) cyc("mem_wait", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    memReadyM = 1;
    cyc("mem_ready", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    memReqM = 0; memReadyM = 0;
    cyc("mem_done", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

    // Timeout: one entry cycle plus four MEM_WAIT cycles
    memReqM = 1;
    for (int i = 0; i < 5; i++) cyc("to_wait", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    memReqM = 0;
    cyc("to_err", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));
    cyc("to_sticky", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));

    // Priority: memory > branch > load-use; branch taken after ready
    PCSrcE = 1; memToRegE = 1; regWriteE = 1; WA3E = 4; ra1D = 4; use1D = 1;
    memReqM = 1;
    cyc("prio_mem", mk(4'b1111, 0, 0, 2'b00, 2'b00, 1));
    cyc("prio_wait", mk(4'b1111, 0, 0, 2'b00, 2'b00, 1));
    memReadyM = 1;
    cyc("prio_ready", mk(4'b1111, 0, 0, 2'b00, 2'b00, 1));
    memReqM = 0; memReadyM = 0;
    cyc("prio_branch", mk(4'b0000, 1, 1, 2'b00, 2'b00, 1));
    clear_inputs();
    cyc("prio_shadow", mk(4'b0000, 1, 0, 2'b00, 2'b00, 1));
    cyc("prio_idle", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));

    // Memory stall during the branch shadow overrides flushD
    PCSrcE = 1;
    cyc("sh_branch", mk(4'b0000, 1, 1, 2'b00, 2'b00, 1));
    PCSrcE = 0; memReqM = 1;
    cyc("sh_memstall", mk(4'b1111, 0, 0, 2'b00, 2'b00, 1));
    memReadyM = 1;
    cyc("sh_ready", mk(4'b1111, 0, 0, 2'b00, 2'b00, 1));
    clear_inputs();
    cyc("sh_idle", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));

    // Reset during BR_SHADOW
    PCSrcE = 1;
    cyc("rsb_branch", mk(4'b0000, 1, 1, 2'b00, 2'b00, 1));
    PCSrcE = 0; rst = 1;
    cyc("rsb_shadow", mk(4'b0000, 1, 0, 2'b00, 2'b00, 1));
    rst = 0;
    cyc("rsb_after", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

    // Reset mid MEM_WAIT, then a full timeout shows the counter restarted
    memReqM = 1;
    for (int i = 0; i < 4; i++) cyc("rsm_wait", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    memReqM = 0; rst = 1;
    cyc("rsm_rst", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    rst = 0;
    cyc("rsm_after", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    memReqM = 1;
    for (int i = 0; i < 5; i++) cyc("rsm_to_wait", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    memReqM = 0;
    cyc("rsm_to_err", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
